pc_predict: RTL and testbench



---
 rtl/pc_predict_pkg.sv | 39 +++
 rtl/pc_predict_btb_array.sv | 57 +++++
 rtl/pc_predict.sv | 117 +++++++++++
 tb/tb_pc_predict.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_predict_pkg.sv
// Shared types for the PC/branch-prediction stage: BTB entry layout,
// 2-bit saturating counter encoding and counter step helpers.
package pc_predict_pkg;

    typedef logic [31:0] word_t;
    // Wide enough to hold pc[31:IDX_W+2] for any BTB depth >= 1; unused upper bits stay zero.
    typedef logic [29:0] tag_t;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic  valid;
        tag_t  tag;
        word_t target;
        ctr_t  ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_inc(input ctr_t c);
        case (c)
            STRONG_NT: return WEAK_NT;
            WEAK_NT:   return WEAK_T;
            default:   return STRONG_T;
        endcase
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        case (c)
            STRONG_T: return WEAK_T;
            WEAK_T:   return WEAK_NT;
            default:  return STRONG_NT;
        endcase
    endfunction

endpackage

// File: rtl/pc_predict_btb_array.sv
// Direct-mapped BTB storage: two combinational read ports (fetch lookup and
// EX training lookup) and one synchronous write port. Reset clears valid
// bits and reloads counters; tags and targets are plain data and not reset.
module btb_array
    import pc_predict_pkg::*;
#(
    parameter int         BTB_ENTRIES = 16,
    parameter logic [1:0] CTR_INIT    = 2'b01
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [$clog2(BTB_ENTRIES)-1:0] rd_a_idx,
    output btb_entry_t                     rd_a_entry,
    input  logic [$clog2(BTB_ENTRIES)-1:0] rd_b_idx,
    output btb_entry_t                     rd_b_entry,
    input  logic                           we,
    input  logic [$clog2(BTB_ENTRIES)-1:0] wr_idx,
    input  btb_entry_t                     wr_entry
);

    logic [BTB_ENTRIES-1:0]       valid_q;
    logic [BTB_ENTRIES-1:0][1:0]  ctr_q;
    tag_t                         tag_q    [BTB_ENTRIES];
    word_t                        target_q [BTB_ENTRIES];

    // Control state: valid bits and counters, cleared/reloaded on reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            ctr_q   <= {BTB_ENTRIES{CTR_INIT}};
        end else if (we) begin
            valid_q[wr_idx] <= wr_entry.valid;
            ctr_q[wr_idx]   <= wr_entry.ctr;
        end
    end

    // Data state: tag and target, written only on an accepted write.
    always_ff @(posedge CLK) begin
        if (we && !RST) begin
            tag_q[wr_idx]    <= wr_entry.tag;
            target_q[wr_idx] <= wr_entry.target;
        end
    end

    // Read ports see the pre-write contents; a same-cycle write shows up next cycle.
    always_comb begin
        rd_a_entry.valid  = valid_q[rd_a_idx];
        rd_a_entry.tag    = tag_q[rd_a_idx];
        rd_a_entry.target = target_q[rd_a_idx];
        rd_a_entry.ctr    = ctr_t'(ctr_q[rd_a_idx]);
        rd_b_entry.valid  = valid_q[rd_b_idx];
        rd_b_entry.tag    = tag_q[rd_b_idx];
        rd_b_entry.target = target_q[rd_b_idx];
        rd_b_entry.ctr    = ctr_t'(ctr_q[rd_b_idx]);
    end

endmodule

// File: rtl/pc_predict.sv
// PC stage upstream of fetch: PC register, BTB-based next-PC prediction,
// mispredict detection/redirect from EX resolution, BTB training and a
// saturating mispredict counter.
module pc_predict
    import pc_predict_pkg::*;
#(
    parameter logic [31:0] PC_INIT     = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        stall,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect,
    output logic [15:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    logic [IDX_W-1:0] lk_idx, ex_idx;
    tag_t             lk_tag, ex_tag;
    btb_entry_t       lk_entry, ex_entry, wr_entry;
    logic             lk_hit, ex_hit, we, mispredict;
    logic [31:0]      ex_pc_plus4;

    assign lk_idx      = pc[IDX_W+1:2];
    assign lk_tag      = tag_t'(pc >> (IDX_W + 2));
    assign ex_idx      = ex_pc[IDX_W+1:2];
    assign ex_tag      = tag_t'(ex_pc >> (IDX_W + 2));
    assign npc         = pc + 32'd4;
    assign ex_pc_plus4 = ex_pc + 32'd4;

    btb_array #(
        .BTB_ENTRIES (BTB_ENTRIES),
        .CTR_INIT    (CTR_INIT)
    ) u_btb (
        .CLK        (CLK),
        .RST        (RST),
        .rd_a_idx   (lk_idx),
        .rd_a_entry (lk_entry),
        .rd_b_idx   (ex_idx),
        .rd_b_entry (ex_entry),
        .we         (we),
        .wr_idx     (ex_idx),
        .wr_entry   (wr_entry)
    );

    // Fetch-side lookup and EX-side mispredict compare.
    always_comb begin
        lk_hit      = lk_entry.valid && (lk_entry.tag == lk_tag);
        ex_hit      = ex_entry.valid && (ex_entry.tag == ex_tag);
        pred_taken  = lk_hit && lk_entry.ctr[1];
        pred_target = lk_hit ? lk_entry.target : npc;
        mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                   (ex_taken && (ex_target != ex_pred_target)));
        redirect    = mispredict;
    end

    // Training: step the counter on a hit, allocate on a taken miss; a halt blocks the write.
    always_comb begin
        we       = 1'b0;
        wr_entry = ex_entry;
        if (ex_valid && !halt) begin
            if (ex_hit) begin
                we           = 1'b1;
                wr_entry.ctr = ex_taken ? ctr_inc(ex_entry.ctr) : ctr_dec(ex_entry.ctr);
                if (ex_taken) begin
                    wr_entry.target = ex_target;
                end
            end else if (ex_taken) begin
                we              = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = ex_tag;
                wr_entry.target = ex_target;
                wr_entry.ctr    = ex_is_branch ? WEAK_T : STRONG_T;
            end
        end
    end

    // PC register: halt beats redirect (halting instruction is older), redirect beats stall.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc <= PC_INIT;
        end else if (halt) begin
            pc <= pc;
        end else if (mispredict) begin
            pc <= ex_taken ? ex_target : ex_pc_plus4;
        end else if (stall || !ihit) begin
            pc <= pc;
        end else begin
            pc <= pred_taken ? pred_target : npc;
        end
    end

    // Saturating mispredict counter for performance monitoring.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mispredict_cnt <= '0;
        end else if (mispredict && (mispredict_cnt != 16'hFFFF)) begin
            mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pc_predict.sv
// Directed bench for pc_predict: reset, sequential fetch, BTB allocate/train,
// counter saturation, jump prediction, aliasing, stall/halt/reset interplay.
module tb_pc_predict;

    logic        CLK = 1'b0;
    logic        RST, ihit, stall, halt;
    logic [31:0] pc, npc, pred_target;
    logic        pred_taken;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        redirect;
    logic [15:0] mispredict_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    pc_predict #(
        .PC_INIT     (32'h0000_0000),
        .BTB_ENTRIES (16),
        .CTR_INIT    (2'b01)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .ihit           (ihit),
        .stall          (stall),
        .halt           (halt),
        .pc             (pc),
        .npc            (npc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect       (redirect),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] a, input logic br, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_pc          = a;
        ex_is_branch   = br;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    // Steer pc to addr with a not-taken resolution at addr-4 that was predicted taken.
    task automatic redirect_to(input logic [31:0] addr);
        set_ex(1'b1, addr - 32'd4, 1'b1, 1'b0, 32'h0, 1'b1, addr);
        step();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp_cnt++;
        #1;
        check("redir_pc", pc, addr);
        check("redir_cnt", 32'(mispredict_cnt), 32'(exp_cnt));
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; stall = 1'b0; halt = 1'b0;
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // 1: reset then sequential fetch
        step(); step();
        check("rst_pc", pc, 32'h0);
        check("rst_cnt", 32'(mispredict_cnt), 32'h0);
        check("rst_pred", 32'(pred_taken), 32'h0);
        check("rst_redir", 32'(redirect), 32'h0);
        RST = 1'b0; ihit = 1'b1;
        #1;
        check("npc0", npc, 32'h4);
        step(); check("seq_pc4", pc, 32'h4);
        step(); check("seq_pc8", pc, 32'h8);
        step(); check("seq_pcC", pc, 32'hC);
        check("seq_pred", 32'(pred_taken), 32'h0);
        ihit = 1'b0;
        step(); check("noihit_hold", pc, 32'hC);
        ihit = 1'b1;
        step(); check("seq_pc10", pc, 32'h10);

        // 2: BEQ at 0x10 taken to 0x40, predicted not-taken
        set_ex(1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 1'b0, 32'h14);
        #1;
        check("beq_redir", 32'(redirect), 32'h1);
        check("beq_rdw_pred", 32'(pred_taken), 32'h0);
        step();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp_cnt++;
        #1;
        check("beq_pc", pc, 32'h40);
        check("beq_cnt", 32'(mispredict_cnt), 32'(exp_cnt));
        redirect_to(32'h10);
        check("beq_pred", 32'(pred_taken), 32'h1);
        check("beq_tgt", pred_target, 32'h40);
        step();
        check("beq_follow", pc, 32'h40);

        // 3: three not-taken resolutions under stall: ctr 10->01->00->00
        redirect_to(32'h10);
        stall = 1'b1;
        set_ex(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
        #1;
        check("nt1_redir", 32'(redirect), 32'h1);
        check("nt1_rdw", 32'(pred_taken), 32'h1);
        step();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp_cnt++;
        #1;
        check("nt1_stall_redir_pc", pc, 32'h14);
        redirect_to(32'h10);
        check("nt1_pred", 32'(pred_taken), 32'h0);
        set_ex(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 32'h14);
        #1;
        check("nt2_redir", 32'(redirect), 32'h0);
        step();
        check("nt2_stall_pc", pc, 32'h10);
        #1;
        check("nt3_redir", 32'(redirect), 32'h0);
        step();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("nt3_pred", 32'(pred_taken), 32'h0);
        // one taken step from the saturated floor must land on weak not-taken
        set_ex(1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 1'b0, 32'h14);
        step();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp_cnt++;
        #1;
        check("sat_pc", pc, 32'h40);
        redirect_to(32'h10);
        check("sat_pred", 32'(pred_taken), 32'h0);

        // 4: J at 0x20 -> 0x100
        stall = 1'b0;
        set_ex(1'b1, 32'h20, 1'b0, 1'b1, 32'h100, 1'b0, 32'h24);
        step();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp_cnt++;
        #1;
        check("j_pc", pc, 32'h100);
        redirect_to(32'h20);
        check("j_pred", 32'(pred_taken), 32'h1);
        check("j_tgt", pred_target, 32'h100);
        step();
        check("j_follow", pc, 32'h100);
        set_ex(1'b1, 32'h20, 1'b0, 1'b1, 32'h100, 1'b1, 32'h100);
        #1;
        check("j_match_redir", 32'(redirect), 32'h0);
        step();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("j_match_pc", pc, 32'h104);

        // 5: alias 0x50 evicts 0x10 (same index)
        set_ex(1'b1, 32'h50, 1'b1, 1'b1, 32'h80, 1'b0, 32'h54);
        step();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp_cnt++;
        #1;
        check("alias_pc", pc, 32'h80);
        redirect_to(32'h10);
        check("alias_miss_pred", 32'(pred_taken), 32'h0);
        check("alias_miss_tgt", pred_target, 32'h14);
        redirect_to(32'h50);
        check("alias_hit_pred", 32'(pred_taken), 32'h1);
        check("alias_hit_tgt", pred_target, 32'h80);

        // 6: halt with mispredict holds pc and blocks training
        halt = 1'b1;
        set_ex(1'b1, 32'h30, 1'b1, 1'b1, 32'h200, 1'b0, 32'h34);
        #1;
        check("halt_redir", 32'(redirect), 32'h1);
        step();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        exp_cnt++;
        #1;
        check("halt_pc", pc, 32'h50);
        halt = 1'b0;
        redirect_to(32'h30);
        check("halt_nowrite", 32'(pred_taken), 32'h0);

        // wrap: 0xFFFF_FFFC + 4 = 0
        redirect_to(32'hFFFF_FFFC);
        check("wrap_npc", npc, 32'h0);
        check("wrap_tgt", pred_target, 32'h0);
        step();
        check("wrap_pc", pc, 32'h0);

        // reset mid-stream clears pc, counter and BTB
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        check("rst2_pc", pc, 32'h0);
        check("rst2_cnt", 32'(mispredict_cnt), 32'h0);
        exp_cnt = 0;
        redirect_to(32'h50);
        check("rst2_miss", 32'(pred_taken), 32'h0);
        redirect_to(32'h20);
        check("rst2_miss_j", 32'(pred_taken), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
